// File: rtl/mix_cols_engine.sv
// mix_cols_engine: iterative AES MixColumns over NB columns, COLS_PER_CYCLE columns per clock.
// Define MIX_COLS_INV_EN to add InvMixColumns, selected per block by in_mode.
module mix_cols_engine #(
    parameter int NB = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [32*NB-1:0] in_state,
    input  logic            in_mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] out_state,
    output logic            busy
);
    localparam int GROUPS = NB / COLS_PER_CYCLE;
    localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;

    if (COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0 || !(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_cfg
        $error("mix_cols_engine: NB must be 4/6/8 and divisible by COLS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [GW-1:0] grp;
    logic [32*NB-1:0] work;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [3:0][7:0] s;
        logic [3:0][7:0] x2;
        logic [3:0][7:0] r;
        for (int i = 0; i < 4; i++) begin
            s[2'(i)] = c[31-8*i -: 8];
            x2[2'(i)] = xt(s[2'(i)]);
        end
        for (int i = 0; i < 4; i++)
            r[2'(i)] = x2[2'(i)] ^ x2[2'(i+1)] ^ s[2'(i+1)] ^ s[2'(i+2)] ^ s[2'(i+3)];
        return {r[0], r[1], r[2], r[3]};
    endfunction

`ifdef MIX_COLS_INV_EN
    logic mode;

    // 9, 11, 13, 14 are assembled from the x2/x4/x8 xtime chain
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [3:0][7:0] s;
        logic [3:0][7:0] x2;
        logic [3:0][7:0] x4;
        logic [3:0][7:0] x8;
        logic [3:0][7:0] r;
        for (int i = 0; i < 4; i++) begin
            s[2'(i)] = c[31-8*i -: 8];
            x2[2'(i)] = xt(s[2'(i)]);
            x4[2'(i)] = xt(x2[2'(i)]);
            x8[2'(i)] = xt(x4[2'(i)]);
        end
        for (int i = 0; i < 4; i++)
            r[2'(i)] = (x8[2'(i)] ^ x4[2'(i)] ^ x2[2'(i)])
                     ^ (x8[2'(i+1)] ^ x2[2'(i+1)] ^ s[2'(i+1)])
                     ^ (x8[2'(i+2)] ^ x4[2'(i+2)] ^ s[2'(i+2)])
                     ^ (x8[2'(i+3)] ^ s[2'(i+3)]);
        return {r[0], r[1], r[2], r[3]};
    endfunction

    function automatic logic [31:0] xform(input logic [31:0] c);
        return mode ? mix_inv(c) : mix_fwd(c);
    endfunction
`else
    logic unused_mode;
    assign unused_mode = in_mode;

    function automatic logic [31:0] xform(input logic [31:0] c);
        return mix_fwd(c);
    endfunction
`endif

    function automatic int col_base(input int g);
        return 32 * (NB - 1 - (int'(grp) * COLS_PER_CYCLE + g));
    endfunction

    assign out_state = work;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            busy <= 1'b0;
            grp <= '0;
            work <= '0;
`ifdef MIX_COLS_INV_EN
            mode <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work <= in_state;
`ifdef MIX_COLS_INV_EN
                    mode <= in_mode;
`endif
                    grp <= '0;
                    state <= BUSY;
                    in_ready <= 1'b0;
                    busy <= 1'b1;
                end
                BUSY: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++)
                        work[col_base(g) +: 32] <= xform(work[col_base(g) +: 32]);
                    grp <= grp + 1'b1;
                    if (grp == GW'(GROUPS - 1)) begin
                        state <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    busy <= 1'b0;
                    grp <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_cols_engine.sv
// tb_mix_cols_engine: three engine configurations checked every cycle against a GF(2^8) matrix model.
module tb_mix_cols_engine;
`ifdef MIX_COLS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif
    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] V2_IN    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_OUT   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_mode = 1'b0;
    logic out_ready = 1'b0;
    logic [31:0] in_cols [8];
    logic [255:0] in8;
    logic [127:0] in4;
    logic rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, bsy_a, bsy_b, bsy_c;
    logic [127:0] oa, ob;
    logic [255:0] oc;
    int total = 0;
    int bad = 0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    assign in8 = {in_cols[0], in_cols[1], in_cols[2], in_cols[3], in_cols[4], in_cols[5], in_cols[6], in_cols[7]};
    assign in4 = in8[255:128];

    mix_cols_engine #(.NB(4), .COLS_PER_CYCLE(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_state(in4), .in_mode(in_mode),
        .out_valid(vld_a), .out_ready(out_ready), .out_state(oa), .busy(bsy_a));
    mix_cols_engine #(.NB(4), .COLS_PER_CYCLE(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_state(in4), .in_mode(in_mode),
        .out_valid(vld_b), .out_ready(out_ready), .out_state(ob), .busy(bsy_b));
    mix_cols_engine #(.NB(8), .COLS_PER_CYCLE(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_state(in8), .in_mode(in_mode),
        .out_valid(vld_c), .out_ready(out_ready), .out_state(oc), .busy(bsy_c));

    function automatic int nbv(input int d);
        return d == 2 ? 8 : 4;
    endfunction

    function automatic int cpv(input int d);
        return d == 0 ? 1 : (d == 1 ? 4 : 2);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] c, input bit inv);
        int cf [4];
        logic [31:0] res = '0;
        logic [7:0] r;
        cf = inv ? '{14, 11, 13, 9} : '{2, 3, 1, 1};
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r ^= gmul(c[31-8*j -: 8], cf[(j - i + 4) % 4]);
            res[31-8*i -: 8] = r;
        end
        return res;
    endfunction

    // Model: phase 0 idle, 1 transforming, 2 holding result; columns finished so far are tracked by steps
    int ph [3] = '{0, 0, 0};
    int steps [3] = '{0, 0, 0};
    bit md [3] = '{0, 0, 0};
    logic [31:0] morig [3][8];
    logic [31:0] mexp [3][8];

    always @(posedge clk) begin
        started <= 1'b1;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                ph[d] <= 0;
                steps[d] <= 0;
                for (int c = 0; c < 8; c++) mexp[d][c] <= '0;
            end else if (ph[d] == 0) begin
                if (in_valid) begin
                    for (int c = 0; c < 8; c++) begin
                        morig[d][c] <= c < nbv(d) ? in_cols[c] : 32'h0;
                        mexp[d][c] <= c < nbv(d) ? in_cols[c] : 32'h0;
                    end
                    md[d] <= INV_EN & in_mode;
                    steps[d] <= 0;
                    ph[d] <= 1;
                end
            end else if (ph[d] == 1) begin
                for (int c = 0; c < nbv(d); c++)
                    if (c >= steps[d] * cpv(d) && c < (steps[d] + 1) * cpv(d))
                        mexp[d][c] <= ref_mix(morig[d][c], md[d]);
                steps[d] <= steps[d] + 1;
                if ((steps[d] + 1) * cpv(d) == nbv(d)) ph[d] <= 2;
            end else if (out_ready) begin
                ph[d] <= 0;
            end
        end
    end

    function automatic logic [255:0] exp_vec(input int d);
        logic [255:0] v = '0;
        for (int c = 0; c < nbv(d); c++) v[255-32*c -: 32] = mexp[d][c];
        return v;
    endfunction

    function automatic logic [255:0] act_vec(input int d);
        return d == 0 ? {oa, 128'h0} : (d == 1 ? {ob, 128'h0} : oc);
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d_in_ready", d), 256'({rdy_c, rdy_b, rdy_a} >> d) & 256'd1, 256'(ph[d] == 0));
                chk($sformatf("d%0d_out_valid", d), 256'({vld_c, vld_b, vld_a} >> d) & 256'd1, 256'(ph[d] == 2));
                chk($sformatf("d%0d_busy", d), 256'({bsy_c, bsy_b, bsy_a} >> d) & 256'd1, 256'(ph[d] != 0));
                chk($sformatf("d%0d_out_state", d), act_vec(d), exp_vec(d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cols(input logic [127:0] v);
        for (int c = 0; c < 8; c++) in_cols[c] = v[127-32*(c%4) -: 32];
    endtask

    task automatic issue(input logic [127:0] v, input logic m);
        set_cols(v);
        in_mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!(vld_a && vld_b && vld_c) && k < 50) begin
            tick();
            k++;
        end
        chk("wait_valid_timeout", 256'(k < 50), 256'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        logic [127:0] hold;
        for (int c = 0; c < 8; c++) in_cols[c] = '0;
        repeat (2) tick();
        chk("reset_out_state", {oa, ob}, 256'h0);
        chk("reset_in_ready", 256'({rdy_a, rdy_b, rdy_c}), 256'd7);
        rst = 1'b0;
        chk("model_fwd_pin", 256'(ref_mix(32'hd4bf5d30, 1'b0)), 256'(32'h046681e5));
        chk("model_inv_pin", 256'(ref_mix(32'h8e4da1bc, 1'b1)), 256'(32'hdb135345));

        issue(FIPS_IN, 1'b0);
        k = 0;
        while (!vld_a && k < 20) begin
            tick();
            k++;
        end
        chk("latency_nb4_cpc1", 256'(k), 256'd4);
        chk("latency_nb8_cpc2", 256'(vld_c), 256'd1);
        chk("fips_nb4_cpc1", 256'(oa), 256'(FIPS_OUT));
        chk("fips_nb4_cpc4", 256'(ob), 256'(FIPS_OUT));
        chk("fips_nb8_cpc2", oc, {FIPS_OUT, FIPS_OUT});
        release_out();

        issue(V2_IN, 1'b0);
        chk("cpc4_not_yet", 256'(vld_b), 256'd0);
        tick();
        chk("latency_nb4_cpc4", 256'(vld_b), 256'd1);
        chk("v2_nb4_cpc4", 256'(ob), 256'(V2_OUT));
        wait_valid();
        release_out();

`ifdef MIX_COLS_INV_EN
        issue(V2_OUT, 1'b1);
        wait_valid();
        chk("inv_nb4_cpc4", 256'(ob), 256'(V2_IN));
        chk("inv_nb4_cpc1", 256'(oa), 256'(V2_IN));
        release_out();
        issue(FIPS_IN, 1'b0);
        wait_valid();
        hold = oa;
        release_out();
        issue(hold, 1'b1);
        wait_valid();
        chk("fwd_inv_roundtrip", 256'(oa), 256'(FIPS_IN));
        release_out();
`endif

        set_cols({$urandom, $urandom, $urandom, $urandom});
        in_valid = 1'b1;
        tick();
        k = 0;
        while (!(vld_a && vld_b && vld_c) && k < 20) begin
            set_cols({$urandom, $urandom, $urandom, $urandom});
            tick();
            k++;
        end
        chk("bp_wait_timeout", 256'(k < 20), 256'd1);
        hold = oa;
        for (int i = 0; i < 10; i++) begin
            set_cols({$urandom, $urandom, $urandom, $urandom});
            tick();
            chk("bp_out_stable", 256'(oa), 256'(hold));
            chk("bp_in_ready_low", 256'(rdy_a), 256'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", 256'(rdy_a), 256'd1);
        chk("bp_hold_after_idle", 256'(oa), 256'(hold));
        tick();
        chk("bp_second_accept", 256'({rdy_a, bsy_a}), 256'b01);
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_valid();
        release_out();

        issue(FIPS_IN, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", 256'(vld_a), 256'd0);
        chk("rst_mid_out_state", 256'(oa), 256'd0);
        chk("rst_mid_in_ready", 256'(rdy_a), 256'd1);
        chk("rst_mid_busy", 256'(bsy_a), 256'd0);
        issue(FIPS_IN, 1'b0);
        wait_valid();
        chk("after_rst_result", 256'(oa), 256'(FIPS_OUT));
        release_out();

        for (int i = 0; i < 2000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            in_mode = 1'($urandom_range(0, 1));
            rst = $urandom_range(0, 199) == 0;
            for (int c = 0; c < 8; c++) in_cols[c] = $urandom;
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
